// File: rtl/light_mgr_pkg.sv
// Shared definitions for the light manager controller.
//   mode_e          : UI mode encoding (SELECT / ADJUST), also the FSM state.
//   DEF_NUM_CH      : default number of light channels.
//   DEF_LEVEL_W     : default brightness level width.
//   timeout_ticks() : clock cycles in an idle-timeout window.
package light_mgr_pkg;

  typedef enum logic {
    MODE_SELECT = 1'b0,
    MODE_ADJUST = 1'b1
  } mode_e;

  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_LEVEL_W = 8;

  // Cycles per timeout window. 64-bit so large frequency * time products
  // cannot overflow.
  function automatic longint timeout_ticks(input int freq_mhz, input int ms);
    return longint'(freq_mhz) * 64'd1000 * longint'(ms);
  endfunction

endpackage

// File: rtl/light_upd_issuer.sv
// Update issuer: tracks which channels hold levels the PWM bank has not yet
// seen, and streams them out one at a time over a valid/ready channel.
//   clk_i, rst_n_i : clock, async active-low reset
//   levels_i       : all channel levels, channel k at [k*LEVEL_W +: LEVEL_W]
//   set_i, set_ch_i: mark channel set_ch_i dirty this cycle
//   upd_valid_o    : payload valid
//   upd_ready_i    : consumer accepts the payload
//   upd_ch_o       : channel of the payload
//   upd_level_o    : level of the payload
//
// Handshake: a transfer happens on a clock edge where upd_valid_o and
// upd_ready_i are both high. While upd_valid_o is high and upd_ready_i is
// low, upd_valid_o, upd_ch_o and upd_level_o do not change.
module light_upd_issuer
  import light_mgr_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int LEVEL_W = DEF_LEVEL_W,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [NUM_CH*LEVEL_W-1:0] levels_i,
  input  logic                      set_i,
  input  logic [CH_W-1:0]           set_ch_i,
  output logic                      upd_valid_o,
  input  logic                      upd_ready_i,
  output logic [CH_W-1:0]           upd_ch_o,
  output logic [LEVEL_W-1:0]        upd_level_o
);

  logic [NUM_CH-1:0]  dirty_q, dirty_d, clr_mask, set_mask;
  logic               load, found;
  logic [CH_W-1:0]    pick;
  logic [LEVEL_W-1:0] pick_level;

  assign load = !upd_valid_o || upd_ready_i;

  // Lowest-index dirty channel wins: scan downwards so the last hit is lowest.
  always_comb begin
    found      = 1'b0;
    pick       = '0;
    pick_level = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (dirty_q[k]) begin
        found      = 1'b1;
        pick       = CH_W'(k);
        pick_level = levels_i[k*LEVEL_W +: LEVEL_W];
      end
    end
  end

  // A set on the same edge as the clear wins, so a value that changed while
  // it was being latched is reissued.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (load && found) clr_mask = NUM_CH'(1) << pick;
    if (set_i)         set_mask = NUM_CH'(1) << set_ch_i;
    dirty_d = (dirty_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dirty_q     <= '1;
      upd_valid_o <= 1'b0;
      upd_ch_o    <= '0;
      upd_level_o <= '0;
    end else begin
      dirty_q <= dirty_d;
      if (load) begin
        upd_valid_o <= found;
        if (found) begin
          upd_ch_o    <= pick;
          upd_level_o <= pick_level;
        end
      end
    end
  end

endmodule

// File: rtl/light_mgr_ctrl.sv
// Light manager controller: two-mode UI (channel select / level adjust)
// driven by rotary-encoder pulses and a button, holding NUM_CH brightness
// registers and streaming level changes to the PWM bank.
//   clk_i, rst_n_i          : clock, async active-low reset
//   left_i, right_i, btn_i  : one-cycle event pulses
//   mode_o                  : 0 = SELECT, 1 = ADJUST (FSM state)
//   ch_sel_o                : selected channel
//   levels_o                : all levels, channel k at [k*LEVEL_W +: LEVEL_W]
//   upd_valid_o/upd_ready_i : update handshake, transfer when both high
//   upd_ch_o, upd_level_o   : update payload, stable while stalled
module light_mgr_ctrl
  import light_mgr_pkg::*;
#(
  parameter int CLOCK_FREQ_MHZ = 100,
  parameter int TIMEOUT_MS     = 5000,
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int LEVEL_W        = DEF_LEVEL_W,
  parameter int STEP           = 8,
  parameter int INIT_LEVEL     = 0,
  localparam int CH_W          = $clog2(NUM_CH)
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      left_i,
  input  logic                      right_i,
  input  logic                      btn_i,
  output logic                      mode_o,
  output logic [CH_W-1:0]           ch_sel_o,
  output logic [NUM_CH*LEVEL_W-1:0] levels_o,
  output logic                      upd_valid_o,
  input  logic                      upd_ready_i,
  output logic [CH_W-1:0]           upd_ch_o,
  output logic [LEVEL_W-1:0]        upd_level_o
);

  localparam longint TICKS = timeout_ticks(CLOCK_FREQ_MHZ, TIMEOUT_MS);
  localparam bit     TO_EN = (TIMEOUT_MS != 0);
  localparam int     CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [LEVEL_W:0] STEP_X  = (LEVEL_W+1)'(STEP);
  localparam logic [LEVEL_W:0] LVL_MAX = {1'b0, {LEVEL_W{1'b1}}};

  // Button has priority; left+right together cancel out.
  logic ev_btn, ev_left, ev_right, any_ev;
  assign ev_btn   = btn_i;
  assign ev_right = !btn_i && right_i && !left_i;
  assign ev_left  = !btn_i && left_i && !right_i;
  assign any_ev   = ev_btn || ev_left || ev_right;

  mode_e             mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              timeout_hit;
  logic [CH_W-1:0]   ch_sel_q;
  logic [LEVEL_W-1:0] level_q [NUM_CH];

  assign timeout_hit = TO_EN && (mode_q == MODE_ADJUST) &&
                       (cnt_q == CNT_W'(TICKS - 64'd1));

  // ---------------- mode FSM ----------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) mode_q <= MODE_SELECT;
    else          mode_q <= mode_d;
  end

  // An event in the same cycle as the timeout counts as activity.
  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      MODE_SELECT: if (ev_btn) mode_d = MODE_ADJUST;
      MODE_ADJUST: if (ev_btn || (timeout_hit && !any_ev)) mode_d = MODE_SELECT;
      default:     mode_d = MODE_SELECT;
    endcase
  end

  always_comb begin
    mode_o = mode_q;
  end

  // ---------------- idle timeout counter ----------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      cnt_q <= '0;
    else if (mode_q == MODE_SELECT || any_ev || timeout_hit)
      cnt_q <= '0;
    else
      cnt_q <= cnt_q + CNT_W'(1);
  end

  // ---------------- channel select ----------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ch_sel_q <= '0;
    end else if (mode_q == MODE_SELECT) begin
      if (ev_right)
        ch_sel_q <= (ch_sel_q == CH_W'(NUM_CH - 1)) ? '0 : ch_sel_q + CH_W'(1);
      else if (ev_left)
        ch_sel_q <= (ch_sel_q == '0) ? CH_W'(NUM_CH - 1) : ch_sel_q - CH_W'(1);
    end
  end

  assign ch_sel_o = ch_sel_q;

  // ---------------- level adjust ----------------
  // Saturating arithmetic in LEVEL_W+1 bits so neither end wraps.
  logic [LEVEL_W:0]   cur_x, sum_x;
  logic [LEVEL_W-1:0] cur, new_level;
  logic               lvl_chg;

  always_comb begin
    cur   = level_q[ch_sel_q];
    cur_x = {1'b0, cur};
    sum_x = cur_x + STEP_X;
    if (ev_right)
      new_level = (sum_x > LVL_MAX) ? LVL_MAX[LEVEL_W-1:0] : sum_x[LEVEL_W-1:0];
    else if (cur_x < STEP_X)
      new_level = '0;
    else
      new_level = cur - STEP_X[LEVEL_W-1:0];
    // Saturated no-ops do not count as changes.
    lvl_chg = (mode_q == MODE_ADJUST) && (ev_right || ev_left) && (new_level != cur);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < NUM_CH; k++) level_q[k] <= LEVEL_W'(INIT_LEVEL);
    end else if (lvl_chg) begin
      level_q[ch_sel_q] <= new_level;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_pack
    assign levels_o[k*LEVEL_W +: LEVEL_W] = level_q[k];
  end

  // ---------------- update issuer ----------------
  light_upd_issuer #(
    .NUM_CH  (NUM_CH),
    .LEVEL_W (LEVEL_W)
  ) u_issuer (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .levels_i    (levels_o),
    .set_i       (lvl_chg),
    .set_ch_i    (ch_sel_q),
    .upd_valid_o (upd_valid_o),
    .upd_ready_i (upd_ready_i),
    .upd_ch_o    (upd_ch_o),
    .upd_level_o (upd_level_o)
  );

endmodule

// File: tb/tb_light_mgr_ctrl.sv
module tb_light_mgr_ctrl;

  localparam int NUM_CH  = 4;
  localparam int LEVEL_W = 8;
  localparam int CH_W    = 2;
  localparam int W       = CH_W + LEVEL_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                      left, right, btn, ready;
  logic                      mode;
  logic [CH_W-1:0]           ch_sel;
  logic [NUM_CH*LEVEL_W-1:0] levels;
  logic                      upd_valid;
  logic [CH_W-1:0]           upd_ch;
  logic [LEVEL_W-1:0]        upd_level;

  light_mgr_ctrl #(
    .CLOCK_FREQ_MHZ (1),
    .TIMEOUT_MS     (1),
    .NUM_CH         (NUM_CH),
    .LEVEL_W        (LEVEL_W),
    .STEP           (8),
    .INIT_LEVEL     (0)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .left_i      (left),
    .right_i     (right),
    .btn_i       (btn),
    .mode_o      (mode),
    .ch_sel_o    (ch_sel),
    .levels_o    (levels),
    .upd_valid_o (upd_valid),
    .upd_ready_i (ready),
    .upd_ch_o    (upd_ch),
    .upd_level_o (upd_level)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  always @(posedge clk) begin
    if (rst_n && upd_valid && ready) got_q.push_back({upd_ch, upd_level});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_updates(input string tag);
    int n;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_payload"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [LEVEL_W-1:0] lvl(input int k);
    return levels[k*LEVEL_W +: LEVEL_W];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic l, input logic r, input logic b);
    left = l; right = r; btn = b;
    tick();
    left = 1'b0; right = 1'b0; btn = 1'b0;
  endtask

  task automatic push_reset_flush();
    for (int k = 0; k < NUM_CH; k++) exp_q.push_back({CH_W'(k), LEVEL_W'(0)});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e;
    rst_n = 1'b0; left = 1'b0; right = 1'b0; btn = 1'b0; ready = 1'b1;
    repeat (3) tick();
    chk("rst_mode", mode, 0);
    chk("rst_ch_sel", ch_sel, 0);
    chk("rst_levels", levels, 0);
    chk("rst_valid", upd_valid, 0);

    // Reset push: ch 0..3 at level 0, then idle.
    rst_n = 1'b1;
    push_reset_flush();
    repeat (6) tick();
    chk("push_idle_valid", upd_valid, 0);
    check_updates("reset_push");

    // Select wrap.
    pulse(1, 0, 0); chk("wrap_left", ch_sel, 3);
    pulse(0, 1, 0); chk("wrap_right0", ch_sel, 0);
    pulse(0, 1, 0); chk("wrap_right1", ch_sel, 1);
    tick();
    check_updates("select_no_upd");

    // Adjust saturation on ch 1.
    pulse(0, 0, 1); chk("enter_adjust", mode, 1);
    for (int i = 1; i <= 40; i++) begin
      pulse(0, 1, 0);
      e = (8 * i > 255) ? 255 : 8 * i;
      chk("sat_up", lvl(1), e);
      if (i <= 32) exp_q.push_back({2'd1, LEVEL_W'(e)});
    end
    repeat (2) tick();
    check_updates("sat_up");
    for (int i = 1; i <= 40; i++) begin
      pulse(1, 0, 0);
      e = (255 - 8 * i < 0) ? 0 : 255 - 8 * i;
      chk("sat_down", lvl(1), e);
      if (i <= 32) exp_q.push_back({2'd1, LEVEL_W'(e)});
    end
    repeat (2) tick();
    check_updates("sat_down");

    // Simultaneous events.
    pulse(1, 1, 0);
    chk("lr_no_change", lvl(1), 0);
    chk("lr_mode", mode, 1);
    tick();
    check_updates("lr_no_upd");
    pulse(0, 0, 1); chk("leave_adjust", mode, 0);
    pulse(0, 1, 1);
    chk("btn_right_mode", mode, 1);
    chk("btn_right_ch", ch_sel, 1);
    pulse(0, 0, 1); chk("leave_adjust2", mode, 0);
    pulse(0, 1, 0); chk("sel_ch2", ch_sel, 2);
    pulse(0, 0, 1); chk("adjust_ch2", mode, 1);

    // Back-pressure coalescing on ch 2.
    ready = 1'b0;
    repeat (3) pulse(0, 1, 0);
    chk("bp_level", lvl(2), 24);
    tick();
    chk("bp_valid", upd_valid, 1);
    chk("bp_ch", upd_ch, 2);
    chk("bp_payload", upd_level, 8);
    repeat (3) tick();
    chk("bp_valid_hold", upd_valid, 1);
    chk("bp_payload_hold", upd_level, 8);
    ready = 1'b1;
    exp_q.push_back({2'd2, 8'd8});
    exp_q.push_back({2'd2, 8'd24});
    repeat (3) tick();
    chk("bp_drained", upd_valid, 0);
    check_updates("coalesce");

    // Timeout: 1000 cycles after the last event.
    pulse(0, 1, 0);
    exp_q.push_back({2'd2, 8'd32});
    repeat (999) tick();
    chk("timeout_not_yet", mode, 1);
    tick();
    chk("timeout_hit", mode, 0);
    check_updates("timeout");

    // Reset while an update is stalled.
    pulse(0, 0, 1);
    ready = 1'b0;
    pulse(0, 1, 0);
    repeat (2) tick();
    chk("stall_valid", upd_valid, 1);
    chk("stall_level", upd_level, 40);
    rst_n = 1'b0;
    #1;
    chk("async_valid", upd_valid, 0);
    chk("async_mode", mode, 0);
    chk("async_levels", levels, 0);
    chk("async_ch_sel", ch_sel, 0);
    repeat (2) tick();
    ready = 1'b1;
    rst_n = 1'b1;
    push_reset_flush();
    repeat (6) tick();
    chk("repush_idle", upd_valid, 0);
    check_updates("repush");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
